// File: rtl/serial_tx_sched_if.sv
// Requester-side bus of serial_tx_sched: per-requester valid/data/endian-select,
// one-hot ready strobe, and the serial line / status outputs.
interface serial_tx_sched_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_big_endian;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      data_out;
  logic                      busy;
  logic [GW-1:0]             grant_id;

  modport master (
    output req_valid, req_data, req_big_endian,
    input  req_ready, data_out, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_big_endian,
    output req_ready, data_out, busy, grant_id
  );
endinterface

// File: rtl/serial_tx_sched.sv
// Round-robin arbiter feeding a UART-style framer (start, DATA_W bits LSB first, stop).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx_sched #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic             clk_in,
  input  logic             rst_in,
  serial_tx_sched_if.slave bus
);
  localparam int unsigned GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DIST_W = GW + 1;
  localparam int unsigned CW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     grant;
  logic [CW-1:0]     baud;
  logic [BW-1:0]     bitn;
  logic [DATA_W-1:0] shreg;
  logic              line;
  logic              busy_q;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
`endif

  logic [DIST_W-1:0] dist_c;
  logic [DIST_W-1:0] best_dist_c;
  logic [GW-1:0]     pick_id_c;
  logic              pick_any_c;
  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] word_c;
  logic              rev_c;
  logic [GW-1:0]     ptr_next_c;
  logic              baud_end_c;
  logic [NUM_REQ-1:0] ready_c;

  // Winner is the valid requester at the smallest rotational distance above ptr.
  always_comb begin
    best_dist_c = DIST_W'(NUM_REQ);
    dist_c      = '0;
    pick_id_c   = '0;
    pick_any_c  = 1'b0;
    raw_c       = '0;
    rev_c       = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (DIST_W'(i) >= {1'b0, ptr})
        dist_c = DIST_W'(i) - {1'b0, ptr};
      else
        dist_c = DIST_W'(i + NUM_REQ) - {1'b0, ptr};
      if (bus.req_valid[i] && (dist_c < best_dist_c)) begin
        best_dist_c = dist_c;
        pick_id_c   = GW'(i);
        pick_any_c  = 1'b1;
        raw_c       = bus.req_data[i*DATA_W +: DATA_W];
        rev_c       = bus.req_big_endian[i];
      end
    end
    word_c = raw_c;
    for (int unsigned b = 0; b < DATA_W; b++)
      word_c[b] = rev_c ? raw_c[DATA_W-1-b] : raw_c[b];
  end

  always_comb begin
    ready_c = '0;
    if (state == S_IDLE && pick_any_c)
      for (int unsigned i = 0; i < NUM_REQ; i++)
        ready_c[i] = (pick_id_c == GW'(i));
  end

  assign ptr_next_c = (pick_id_c == GW'(NUM_REQ-1)) ? '0 : pick_id_c + GW'(1);
  assign baud_end_c = (baud == CW'(CLKS_PER_BIT-1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= S_IDLE;
      ptr    <= '0;
      grant  <= '0;
      baud   <= '0;
      bitn   <= '0;
      shreg  <= '0;
      line   <= 1'b1;
      busy_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_any_c) begin
            shreg  <= word_c;
`ifdef SERIAL_TX_PARITY_EN
            par    <= ^word_c;
`endif
            grant  <= pick_id_c;
            ptr    <= ptr_next_c;
            busy_q <= 1'b1;
            line   <= 1'b0;
            baud   <= '0;
            state  <= S_START;
          end
        end
        S_START: begin
          if (baud_end_c) begin
            baud  <= '0;
            bitn  <= '0;
            line  <= shreg[0];
            shreg <= shreg >> 1;
            state <= S_DATA;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_end_c) begin
            baud <= '0;
            if (bitn == BW'(DATA_W-1)) begin
`ifdef SERIAL_TX_PARITY_EN
              line  <= par;
              state <= S_PARITY;
`else
              line  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bitn  <= bitn + BW'(1);
              line  <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end_c) begin
            baud  <= '0;
            line  <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // Leaving STOP drops busy; the following IDLE cycle may accept again.
          if (baud_end_c) begin
            baud   <= '0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.data_out  = line;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant;
endmodule

// File: tb/tb_serial_tx_sched.sv
// Bench for serial_tx_sched: per-cycle comparison against a queue-based line model,
// directed literal scenarios, then randomized multi-requester traffic.
module tb_serial_tx_sched;
  localparam int unsigned NR  = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
  localparam int unsigned GW  = $clog2(NR);
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned NBITS = DW + 3;
`else
  localparam int unsigned NBITS = DW + 2;
`endif
  localparam int unsigned FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();

  serial_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: expected line level for each upcoming cycle; empty means idle.
  bit mq[$];
  int m_ptr   = 0;
  int m_grant = 0;
  logic [NR-1:0] took = '0;

  bit [NR-1:0]   v;
  bit [NR-1:0]   be;
  logic [DW-1:0] d [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req_valid      = v;
    bus.req_big_endian = be;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = d[i];
  endtask

  function automatic void push_frame(input logic [DW-1:0] w, input bit bend);
    logic [DW-1:0] o;
    for (int k = 0; k < DW; k++) o[k] = bend ? w[DW-1-k] : w[k];
    repeat (CPB) mq.push_back(1'b0);
    for (int k = 0; k < DW; k++) repeat (CPB) mq.push_back(o[k]);
`ifdef SERIAL_TX_PARITY_EN
    repeat (CPB) mq.push_back(^o);
`endif
    repeat (CPB) mq.push_back(1'b1);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ptr   = 0;
    m_grant = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [NR-1:0] er;
      int pick;
      bit exp_line;
      er   = '0;
      pick = -1;
      if (mq.size() == 0)
        for (int k = 0; k < NR; k++)
          if (pick < 0 && bus.req_valid[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
      if (pick >= 0) er[pick] = 1'b1;
      exp_line = (mq.size() == 0) ? 1'b1 : mq[0];
      check("data_out", 32'(bus.data_out), 32'(exp_line));
      check("busy", 32'(bus.busy), 32'(mq.size() != 0));
      check("req_ready", 32'(bus.req_ready), 32'(er));
      check("grant_id", 32'(bus.grant_id), 32'(m_grant));
      took = bus.req_valid & bus.req_ready;
      if (mq.size() != 0) begin
        void'(mq.pop_front());
      end else if (pick >= 0) begin
        push_frame(bus.req_data[pick*DW +: DW], bus.req_big_endian[pick]);
        m_grant = pick;
        m_ptr   = (pick + 1) % NR;
      end
    end
  end

  task automatic wait_ready(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready == '0 && n < limit);
    check({name, "_ready_seen"}, 32'(|bus.req_ready), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < limit);
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  // Single requester-0 frame, sampled at bit centres against a literal bit pattern.
  task automatic lit_frame(input string name, input logic [DW-1:0] data, input bit bend,
                           input bit [NBITS-1:0] exp_bits);
    int busy_n;
    bit samp [FRAME+4];
    @(posedge clk); #1;
    v = '0; v[0] = 1'b1; d[0] = data; be = '0; be[0] = bend;
    drive();
    wait_ready(name, 20);
    check({name, "_ready_onehot"}, 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    v = '0;
    drive();
    busy_n = 0;
    for (int c = 0; c < FRAME + 4; c++) begin
      @(negedge clk);
      samp[c] = bus.data_out;
      busy_n += int'(bus.busy);
    end
    check({name, "_busy_len"}, 32'(busy_n), 32'(FRAME));
    check({name, "_grant"}, 32'(bus.grant_id), 32'd0);
    for (int j = 0; j < NBITS; j++)
      check({name, "_bit"}, 32'(samp[j*CPB + CPB/2]), 32'(exp_bits[j]));
  endtask

  int gseq [3];
  int gt   [3];

  initial begin
    int bad;
    int got;
    int cyc;
    v = '0; be = '0;
    for (int i = 0; i < NR; i++) d[i] = '0;
    drive();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_data_out", 32'(bus.data_out), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_grant", 32'(bus.grant_id), 32'd0);
    #1 rst = 1'b0;

    // No requests: line stays idle.
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.data_out !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== '0) bad++;
    end
    check("t5_idle_cycles_bad", 32'(bad), 32'd0);

`ifdef SERIAL_TX_PARITY_EN
    lit_frame("t1", 8'hA5, 1'b0, 11'b10101001010);
    lit_frame("t2", 8'h01, 1'b1, 11'b11100000000);
    lit_frame("t6", 8'h07, 1'b0, 11'b11000001110);
`else
    lit_frame("t1", 8'hA5, 1'b0, 10'b1101001010);
    lit_frame("t2", 8'h01, 1'b1, 10'b1100000000);
`endif

    // Fresh reset so rotation starts at requester 0.
    @(posedge clk); #3 rst = 1'b1;
    #1 model_reset();
    @(posedge clk); #3 rst = 1'b0;

    @(posedge clk); #1;
    v = 3'b011; d[0] = 8'h11; d[1] = 8'h22; be = '0;
    drive();
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 4 * (FRAME + 1)) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        gseq[got] = int'(bus.req_ready);
        gt[got]   = cyc;
        got++;
      end
      cyc++;
    end
    check("t3_accepts", 32'(got), 32'd3);
    check("t3_grant0", 32'(gseq[0]), 32'h1);
    check("t3_grant1", 32'(gseq[1]), 32'h2);
    check("t3_grant2", 32'(gseq[2]), 32'h1);
    check("t3_spacing01", 32'(gt[1] - gt[0]), 32'(FRAME + 1));
    check("t3_spacing12", 32'(gt[2] - gt[1]), 32'(FRAME + 1));
    @(posedge clk); #1;
    v = '0;
    drive();
    wait_idle("t3", 2 * FRAME);

    // Reset in the middle of data bit 3 (cycles 16..19 after the accept edge).
    @(posedge clk); #1;
    v = 3'b001; d[0] = 8'h30; be = '0;
    drive();
    wait_ready("t4_first", 20);
    @(posedge clk);
    repeat (17) @(posedge clk);
    #3;
    check("t4_line_before_rst", 32'(bus.data_out), 32'd0);
    rst = 1'b1;
    #1;
    check("t4_line_async", 32'(bus.data_out), 32'd1);
    check("t4_busy_async", 32'(bus.busy), 32'd0);
    model_reset();
    @(posedge clk); #3 rst = 1'b0;
    wait_ready("t4_again", 20);
    check("t4_reaccept", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    v = '0;
    drive();
    wait_idle("t4", 2 * FRAME);

    // Randomized traffic; requesters hold valid/data until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (took[i] || !v[i]) begin
          v[i]  = ($urandom_range(0, 3) != 0);
          d[i]  = DW'($urandom);
          be[i] = 1'($urandom_range(0, 1));
        end
      end
      drive();
    end
    @(posedge clk); #1;
    v = '0;
    drive();
    wait_idle("final", 2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
